// File: rtl/pwm_fade_ctrl_if.sv
// Control/status bundle between a fade sequencer (master) and pwm_fade_ctrl (slave).
// fsm_state mirrors the controller's state register for observation.
interface pwm_fade_ctrl_if #(
  parameter int BIT_WIDTH      = 8,
  parameter int INTERVAL_WIDTH = 16
);
  // start/stop are single-cycle strobes, sampled on the rising clock edge;
  // there is no ready: a request is always accepted, and stop wins over start.
  logic                      start;
  logic                      stop;
  logic [BIT_WIDTH-1:0]      target_duty;
  logic [BIT_WIDTH-1:0]      step_size;
  logic [INTERVAL_WIDTH-1:0] step_interval;
  logic [BIT_WIDTH-1:0]      max_value;
  logic                      breathe;
  logic [BIT_WIDTH-1:0]      duty;
  logic                      busy;
  logic                      done;
  logic [1:0]                fsm_state;

  modport master (
    output start, stop, target_duty, step_size, step_interval, max_value, breathe,
    input  duty, busy, done, fsm_state
  );

  modport slave (
    input  start, stop, target_duty, step_size, step_interval, max_value, breathe,
    output duty, busy, done, fsm_state
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Ramps a PWM duty value toward a clamped target in fixed steps every interval+1 cycles.
// Optional continuous up/down breathing is enabled with the PWM_FADE_BREATHE_EN macro.
module pwm_fade_ctrl #(
  parameter int BIT_WIDTH      = 8,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  pwm_fade_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    state_q;
  logic [BIT_WIDTH-1:0]      duty_q;
  logic                      busy_q;
  logic                      done_q;
  logic [INTERVAL_WIDTH-1:0] presc_q;
  logic [INTERVAL_WIDTH-1:0] interval_q;
  logic [BIT_WIDTH-1:0]      tgt_q;
  logic [BIT_WIDTH-1:0]      step_q;
`ifdef PWM_FADE_BREATHE_EN
  logic                      dir_down_q;
`endif

  logic [BIT_WIDTH-1:0] endpoint;
  logic [BIT_WIDTH-1:0] next_duty;
  logic [BIT_WIDTH-1:0] clamp_tgt;
  logic [BIT_WIDTH-1:0] start_step;
  logic                 tick;
  logic                 reached;
  logic                 breathe_mode;

  always_comb begin
    endpoint     = tgt_q;
    breathe_mode = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
    breathe_mode = bus.breathe;
    if (dir_down_q) endpoint = '0;
`endif
    // Compare the remaining distance to the step instead of adding first,
    // so the step can never overshoot, underflow or wrap.
    next_duty = duty_q;
    if (duty_q < endpoint)
      next_duty = ((endpoint - duty_q) <= step_q) ? endpoint : duty_q + step_q;
    else if (duty_q > endpoint)
      next_duty = ((duty_q - endpoint) <= step_q) ? endpoint : duty_q - step_q;
    tick       = (presc_q == interval_q);
    reached    = (duty_q == endpoint) || (tick && (next_duty == endpoint));
    clamp_tgt  = (bus.target_duty > bus.max_value) ? bus.max_value : bus.target_duty;
    start_step = (bus.step_size == '0) ? BIT_WIDTH'(1) : bus.step_size;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      interval_q <= '0;
      tgt_q      <= '0;
      step_q     <= BIT_WIDTH'(1);
`ifdef PWM_FADE_BREATHE_EN
      dir_down_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (bus.start) begin
        // Retarget keeps duty_q where it is; only the fade parameters change.
        state_q    <= RAMP;
        busy_q     <= 1'b1;
        tgt_q      <= clamp_tgt;
        step_q     <= start_step;
        interval_q <= bus.step_interval;
        presc_q    <= '0;
`ifdef PWM_FADE_BREATHE_EN
        dir_down_q <= 1'b0;
`endif
      end else if (state_q == RAMP) begin
        if (tick) begin
          presc_q <= '0;
          duty_q  <= next_duty;
        end else begin
          presc_q <= presc_q + INTERVAL_WIDTH'(1);
        end
        if (reached) begin
          done_q <= 1'b1;
          if (breathe_mode) begin
`ifdef PWM_FADE_BREATHE_EN
            dir_down_q <= ~dir_down_q;
`endif
          end else begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.duty      = duty_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: ramps, saturation, clamping, retarget,
// stop/start priority, asynchronous reset and (with PWM_FADE_BREATHE_EN) breathing.
module tb_pwm_fade_ctrl;
  localparam int BW = 8;
  localparam int IW = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  pwm_fade_ctrl_if #(.BIT_WIDTH(BW), .INTERVAL_WIDTH(IW)) bus ();

  pwm_fade_ctrl #(.BIT_WIDTH(BW), .INTERVAL_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start is seen on the following posedge and the task
  // returns at the negedge right after that edge.
  task automatic drive_start(input logic [BW-1:0] tgt, input logic [BW-1:0] step,
                             input logic [IW-1:0] intv, input logic [BW-1:0] maxv);
    bus.target_duty   = tgt;
    bus.step_size     = step;
    bus.step_interval = intv;
    bus.max_value     = maxv;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start         = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.target_duty   = '0;
    bus.step_size     = '0;
    bus.step_interval = '0;
    bus.max_value     = 8'd255;
    bus.breathe       = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    @(negedge clk);

    check("reset_duty", 32'(bus.duty), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_state", 32'(bus.fsm_state), 32'(S_IDLE));

    // 0 -> 100, step 10, interval 3: one update every 4 cycles
    drive_start(8'd100, 8'd10, 16'd3, 8'd255);
    check("up_busy", 32'(bus.busy), 32'd1);
    check("up_state", 32'(bus.fsm_state), 32'(S_RAMP));
    for (int k = 1; k <= 10; k++) begin
      wait_cycles(3);
      check("up_between_ticks", 32'(bus.duty), 32'(10 * (k - 1)));
      check("up_done_early", 32'(bus.done), 32'd0);
      wait_cycles(1);
      check("up_tick", 32'(bus.duty), 32'(10 * k));
      check("up_done", 32'(bus.done), (k == 10) ? 32'd1 : 32'd0);
    end
    check("up_hold_state", 32'(bus.fsm_state), 32'(S_HOLD));
    check("up_hold_busy", 32'(bus.busy), 32'd0);
    wait_cycles(1);
    check("up_done_single", 32'(bus.done), 32'd0);
    wait_cycles(5);
    check("up_hold_duty", 32'(bus.duty), 32'd100);

    // start with target equal to current duty
    drive_start(8'd100, 8'd5, 16'd3, 8'd255);
    check("eq_state_ramp", 32'(bus.fsm_state), 32'(S_RAMP));
    check("eq_duty_ramp", 32'(bus.duty), 32'd100);
    wait_cycles(1);
    check("eq_state_hold", 32'(bus.fsm_state), 32'(S_HOLD));
    check("eq_done", 32'(bus.done), 32'd1);
    check("eq_duty_hold", 32'(bus.duty), 32'd100);
    wait_cycles(1);
    check("eq_done_clear", 32'(bus.done), 32'd0);

    // 100 -> 5 in steps of 30: saturates at 5 without underflow
    drive_start(8'd5, 8'd30, 16'd0, 8'd255);
    check("down_first", 32'(bus.duty), 32'd100);
    wait_cycles(1); check("down_70", 32'(bus.duty), 32'd70);
    wait_cycles(1); check("down_40", 32'(bus.duty), 32'd40);
    wait_cycles(1); check("down_10", 32'(bus.duty), 32'd10);
    check("down_no_done_10", 32'(bus.done), 32'd0);
    wait_cycles(1); check("down_5", 32'(bus.duty), 32'd5);
    check("down_done", 32'(bus.done), 32'd1);
    check("down_hold", 32'(bus.fsm_state), 32'(S_HOLD));

    // target 250 clamped to max_value 200
    pulse_reset();
    drive_start(8'd250, 8'd60, 16'd0, 8'd200);
    wait_cycles(1); check("clamp_60", 32'(bus.duty), 32'd60);
    wait_cycles(1); check("clamp_120", 32'(bus.duty), 32'd120);
    wait_cycles(1); check("clamp_180", 32'(bus.duty), 32'd180);
    wait_cycles(1); check("clamp_200", 32'(bus.duty), 32'd200);
    check("clamp_done", 32'(bus.done), 32'd1);
    wait_cycles(3);
    check("clamp_hold_duty", 32'(bus.duty), 32'd200);
    check("clamp_hold_state", 32'(bus.fsm_state), 32'(S_HOLD));

    // retarget mid-ramp at 40 toward 0, then start+stop together
    pulse_reset();
    drive_start(8'd100, 8'd10, 16'd1, 8'd255);
    wait_cycles(8);
    check("rt_at_40", 32'(bus.duty), 32'd40);
    drive_start(8'd0, 8'd10, 16'd1, 8'd255);
    check("rt_no_jump", 32'(bus.duty), 32'd40);
    check("rt_busy", 32'(bus.busy), 32'd1);
    wait_cycles(1); check("rt_wait", 32'(bus.duty), 32'd40);
    wait_cycles(1); check("rt_30", 32'(bus.duty), 32'd30);
    wait_cycles(2); check("rt_20", 32'(bus.duty), 32'd20);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.target_duty = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_state", 32'(bus.fsm_state), 32'(S_IDLE));
    check("ss_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("ss_duty_frozen", 32'(bus.duty), 32'd20);
      check("ss_no_done", 32'(bus.done), 32'd0);
      wait_cycles(1);
    end

    // asynchronous reset between edges during a ramp
    drive_start(8'd100, 8'd10, 16'd0, 8'd255);
    wait_cycles(2);
    check("ar_pre_duty", 32'(bus.duty), 32'd40);
    #2 rst = 1'b1;
    #1;
    check("ar_duty", 32'(bus.duty), 32'd0);
    check("ar_state", 32'(bus.fsm_state), 32'(S_IDLE));
    check("ar_busy", 32'(bus.busy), 32'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ar_post_duty", 32'(bus.duty), 32'd0);
      check("ar_post_done", 32'(bus.done), 32'd0);
    end

`ifdef PWM_FADE_BREATHE_EN
    begin
      logic [BW-1:0] br_duty [6];
      logic          br_done [6];
      br_duty = '{8'd10, 8'd20, 8'd10, 8'd0, 8'd10, 8'd20};
      br_done = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bus.breathe = 1'b1;
      drive_start(8'd20, 8'd10, 16'd0, 8'd255);
      for (int k = 0; k < 6; k++) begin
        wait_cycles(1);
        check("br_duty", 32'(bus.duty), 32'(br_duty[k]));
        check("br_done", 32'(bus.done), 32'(br_done[k]));
        check("br_busy", 32'(bus.busy), 32'd1);
      end
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop    = 1'b0;
      bus.breathe = 1'b0;
      check("br_stop_state", 32'(bus.fsm_state), 32'(S_IDLE));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
